// File: rtl/sigmoid_lut_pkg.sv
// Shared types and helpers for the sigmoid LUT arbiter.
package sigmoid_lut_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2,
        DRAIN   = 2'd3
    } lut_state_t;

    function automatic int mem_size(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/sigmoid_lut_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req, pointer moves past the winner.
// Latency 0 (grant is combinational); en=0 withholds all grants and freezes the pointer.
module rr_arbiter
    import sigmoid_lut_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] cand;
    logic          found;

    // Scan from rr_ptr upward, folding indices >= N back to the bottom.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found              = 1'b1;
                gnt_idx            = cand[IW-1:0];
                gnt[cand[IW-1:0]]  = en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (en && found) begin
            rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sigmoid_lut_arbiter.sv
// Runtime-loaded sigmoid LUT shared round-robin by NUM_REQ streams; SIGMOID_ARB_STATS_EN adds counters.
// Latency 1 cycle accept->result; result holds while data_out_0_ready=0, which also blocks grants.
module sigmoid_lut_arbiter
    import sigmoid_lut_pkg::*;
#(
    parameter int NUM_REQ                = 4,
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 4,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_start,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]  cfg_data,
    output logic                               lut_loaded,
    input  logic [DATA_IN_0_PRECISION_0-1:0]   data_in_0 [NUM_REQ],
    input  logic [NUM_REQ-1:0]                 data_in_0_valid,
    output logic [NUM_REQ-1:0]                 data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0]  data_out_0,
    output logic [$clog2(NUM_REQ)-1:0]         data_out_0_id,
    output logic                               data_out_0_valid,
    input  logic                               data_out_0_ready
`ifdef SIGMOID_ARB_STATS_EN
    ,
    output logic [31:0]                        stat_grants [NUM_REQ],
    output logic [31:0]                        stat_stall
`endif
);

    localparam int INW       = DATA_IN_0_PRECISION_0;
    localparam int OUTW      = DATA_OUT_0_PRECISION_0;
    localparam int IDW       = $clog2(NUM_REQ);
    localparam int MEM_SIZE  = mem_size(INW);
    localparam logic [INW-1:0] LAST_ADDR = INW'(MEM_SIZE - 1);

    if (NUM_REQ < 2 || DATA_IN_0_PRECISION_1 > INW || DATA_OUT_0_PRECISION_1 > OUTW) begin : g_bad_cfg
        $error("sigmoid_lut_arbiter: illegal parameter combination");
    end

    lut_state_t        state, state_nxt;
    logic [INW-1:0]    load_addr;
    logic [OUTW-1:0]   lut [MEM_SIZE];
    logic              cfg_fire;
    logic              can_issue;
    logic              arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]    gnt_idx;

    assign can_issue       = !data_out_0_valid || data_out_0_ready;
    assign cfg_fire        = cfg_ready && cfg_valid && !cfg_start;
    assign data_in_0_ready = gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (cfg_start) state_nxt = LOADING;
            LOADING: if (cfg_fire && load_addr == LAST_ADDR) state_nxt = READY;
            READY:   if (cfg_start) state_nxt = DRAIN;
            DRAIN:   if (can_issue) state_nxt = LOADING;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        cfg_ready  = (state == LOADING);
        lut_loaded = (state == READY);
        arb_en     = (state == READY) && can_issue;
    end

    // Held at zero outside LOADING so every entry into LOADING starts at address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_addr <= '0;
        end else if (state != LOADING || cfg_start) begin
            load_addr <= '0;
        end else if (cfg_fire) begin
            load_addr <= load_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_fire) begin
            lut[load_addr] <= cfg_data;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (data_in_0_valid),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0       <= '0;
            data_out_0_id    <= '0;
            data_out_0_valid <= 1'b0;
        end else if (|gnt) begin
            data_out_0       <= lut[data_in_0[gnt_idx]];
            data_out_0_id    <= gnt_idx;
            data_out_0_valid <= 1'b1;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

`ifdef SIGMOID_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) stat_grants[i] <= '0;
            stat_stall <= '0;
        end else if (cfg_start) begin
            for (int i = 0; i < NUM_REQ; i++) stat_grants[i] <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && stat_grants[i] != '1) stat_grants[i] <= stat_grants[i] + 32'd1;
            end
            if (|data_in_0_valid && !(|gnt) && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed + randomized bench for sigmoid_lut_arbiter against a spec-level model and result scoreboard.
module tb_sigmoid_lut_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready;
    logic       lut_loaded;
    logic [7:0] din [4];
    logic [3:0] din_vld = 4'b0000;
    logic [3:0] data_in_0_ready;
    logic [7:0] data_out_0;
    logic [1:0] data_out_0_id;
    logic       data_out_0_valid;
    logic       out_rdy = 1'b0;
`ifdef SIGMOID_ARB_STATS_EN
    logic [31:0] stat_grants [4];
    logic [31:0] stat_stall;
`endif

    sigmoid_lut_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_data         (cfg_data),
        .lut_loaded       (lut_loaded),
        .data_in_0        (din),
        .data_in_0_valid  (din_vld),
        .data_in_0_ready  (data_in_0_ready),
        .data_out_0       (data_out_0),
        .data_out_0_id    (data_out_0_id),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (out_rdy)
`ifdef SIGMOID_ARB_STATS_EN
        ,
        .stat_grants      (stat_grants),
        .stat_stall       (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int dat;
    } res_t;

    int         tests = 0;
    int         fails = 0;
    int         m_phase;   // 0 empty, 1 loading, 2 serving, 3 draining
    int         m_addr;
    int         m_rr;
    int         m_grants [4];
    int         m_stall;
    logic [7:0] m_lut [256];
    logic [7:0] newv [256];
    res_t       sb [$];
    logic [3:0] obs_rdy;
    logic [7:0] hold_dat;
    logic [1:0] hold_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_addr  = 0;
        m_rr    = 0;
        m_stall = 0;
        for (int i = 0; i < 4; i++) m_grants[i] = 0;
        sb.delete();
    endtask

    // One clock: inputs already driven; check at the falling edge, advance model, return at posedge+1.
    task automatic cycle(input string tag);
        int   g;
        bit   had;
        bit   can;
        res_t r;
        #4;
        obs_rdy = data_in_0_ready;
        had = (sb.size() > 0);
        can = !had || out_rdy;
        g = -1;
        if (m_phase == 2 && can) begin
            for (int i = 0; i < 4; i++) begin
                if (g < 0 && din_vld[(m_rr + i) % 4]) g = (m_rr + i) % 4;
            end
        end
        chk({tag, ".gnt"}, 32'(data_in_0_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(m_phase == 1));
        chk({tag, ".lut_loaded"}, 32'(lut_loaded), 32'(m_phase == 2));
        chk({tag, ".out_valid"}, 32'(data_out_0_valid), 32'(had));
        if (had) begin
            chk({tag, ".out_data"}, 32'(data_out_0), 32'(sb[0].dat));
            chk({tag, ".out_id"}, 32'(data_out_0_id), 32'(sb[0].id));
        end
`ifdef SIGMOID_ARB_STATS_EN
        for (int i = 0; i < 4; i++) chk({tag, ".stat_grants"}, stat_grants[i], 32'(m_grants[i]));
        chk({tag, ".stat_stall"}, stat_stall, 32'(m_stall));
`endif
        if (had && out_rdy) void'(sb.pop_front());
        if (g >= 0) begin
            r.id  = g;
            r.dat = int'(m_lut[din[g]]);
            sb.push_back(r);
            m_rr = (g + 1) % 4;
        end
        if (cfg_start) begin
            for (int i = 0; i < 4; i++) m_grants[i] = 0;
            m_stall = 0;
        end else begin
            if (g >= 0) m_grants[g]++;
            if (din_vld != 4'b0000 && g < 0) m_stall++;
        end
        case (m_phase)
            0: if (cfg_start) begin m_phase = 1; m_addr = 0; end
            1: begin
                if (cfg_start) m_addr = 0;
                else if (cfg_valid) begin
                    m_lut[m_addr] = cfg_data;
                    if (m_addr == 255) m_phase = 2;
                    m_addr = (m_addr + 1) % 256;
                end
            end
            2: if (cfg_start) m_phase = 3;
            default: if (!had || out_rdy) begin m_phase = 1; m_addr = 0; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, ".lut_loaded"}, 32'(lut_loaded), 32'd0);
        chk({tag, ".gnt"}, 32'(data_in_0_ready), 32'd0);
        chk({tag, ".out_valid"}, 32'(data_out_0_valid), 32'd0);
        chk({tag, ".out_data"}, 32'(data_out_0), 32'd0);
        chk({tag, ".out_id"}, 32'(data_out_0_id), 32'd0);
`ifdef SIGMOID_ARB_STATS_EN
        chk({tag, ".stat_grants2"}, stat_grants[2], 32'd0);
        chk({tag, ".stat_stall"}, stat_stall, 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        reset_checks(tag);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic wait_loading(input string tag);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            cycle(tag);
            n++;
        end
        chk({tag, ".enter_loading"}, 32'(cfg_ready), 32'd1);
    endtask

    task automatic start_load(input string tag);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        cycle(tag);
        cfg_start = 1'b0;
        wait_loading(tag);
    endtask

    task automatic load_entries(input int n, input string tag);
        int  done  = 0;
        int  guard = 0;
        bit  fired;
        while (done < n && guard < 4000) begin
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_data  = newv[m_addr];
            fired     = cfg_valid;
            cycle(tag);
            if (fired) done++;
            guard++;
        end
        cfg_valid = 1'b0;
        chk({tag, ".writes_done"}, 32'(done), 32'(n));
    endtask

    task automatic rand_traffic(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            din_vld = 4'($urandom);
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle(tag);
        end
        din_vld = 4'b0000;
        out_rdy = 1'b1;
        cycle(tag);
        cycle(tag);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        for (int i = 0; i < 256; i++) m_lut[i] = 8'h00;
        model_clear();
        din_vld = 4'b1111;

        // Reset state with requests pending
        #2 rst = 1'b0;
        #1 reset_checks("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        repeat (2) cycle("empty");

        // 1: load i^A5, single lookup of address 0
        din_vld = 4'b0000;
        for (int i = 0; i < 256; i++) newv[i] = 8'(i) ^ 8'hA5;
        start_load("t1_start");
        load_entries(256, "t1_load");
        chk("t1_loaded", 32'(lut_loaded), 32'd1);
        din[0] = 8'h00;
        din_vld = 4'b0001;
        out_rdy = 1'b1;
        cycle("t1_acc");
        chk("t1_gnt", 32'(obs_rdy), 32'h1);
        chk("t1_vld", 32'(data_out_0_valid), 32'd1);
        chk("t1_dat", 32'(data_out_0), 32'hA5);
        chk("t1_id", 32'(data_out_0_id), 32'd0);
        din_vld = 4'b0000;
        cycle("t1_idle");

        // 3: pointer at 1, only req3 valid, then all valid starts at req0
        din_vld = 4'b1000;
        din[3] = 8'h7F;
        cycle("t3_req3");
        chk("t3_gnt3", 32'(obs_rdy), 32'h8);
        // 2: all valid continuously -> 0,1,2,3,0,...
        din_vld = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
            cycle("t2_stream");
            chk("t2_seq", 32'(obs_rdy), 32'(1 << (c % 4)));
            chk("t2_no_gap", 32'(data_out_0_valid), 32'd1);
        end

        // 4: backpressure for 5 cycles
        out_rdy = 1'b0;
        hold_dat = data_out_0;
        hold_id = data_out_0_id;
        for (int c = 0; c < 5; c++) begin
            cycle("t4_hold");
            chk("t4_no_gnt", 32'(obs_rdy), 32'd0);
            chk("t4_dat_stable", 32'(data_out_0), 32'(hold_dat));
            chk("t4_id_stable", 32'(data_out_0_id), 32'(hold_id));
        end
        out_rdy = 1'b1;
        repeat (6) cycle("t4_release");

        // 5: reload while a result is pending; restart mid-load
        out_rdy = 1'b0;
        cycle("t5_pend");
        cfg_start = 1'b1;
        cycle("t5_start");
        cfg_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle("t5_drain");
            chk("t5_no_gnt", 32'(obs_rdy), 32'd0);
        end
        out_rdy = 1'b1;
        wait_loading("t5_wait");
        for (int i = 0; i < 256; i++) newv[i] = 8'($urandom);
        load_entries(50, "t5_load_a");
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        cycle("t5_restart");
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        load_entries(256, "t5_load_b");
        chk("t5_loaded", 32'(lut_loaded), 32'd1);
        rand_traffic(150, "t5_rand");

        // 6: reset after 100 load writes, then full reload
        start_load("t6_start");
        for (int i = 0; i < 256; i++) newv[i] = 8'(i) ^ 8'h3C;
        load_entries(100, "t6_load_part");
        din_vld = 4'b1111;
        do_reset("t6_reset");
        for (int c = 0; c < 3; c++) begin
            cycle("t6_empty");
            chk("t6_no_gnt", 32'(obs_rdy), 32'd0);
        end
        din_vld = 4'b0000;
        start_load("t6_reload");
        load_entries(256, "t6_load_full");
        chk("t6_loaded", 32'(lut_loaded), 32'd1);

`ifdef SIGMOID_ARB_STATS_EN
        // 7: per-requester counter and clear on cfg_start
        din_vld = 4'b0100;
        din[2] = 8'h10;
        out_rdy = 1'b1;
        repeat (10) cycle("t7_req2");
        din_vld = 4'b0000;
        chk("t7_grants2", stat_grants[2], 32'd10);
        start_load("t7_clear");
        chk("t7_cleared", stat_grants[2], 32'd0);
        for (int i = 0; i < 256; i++) newv[i] = 8'($urandom);
        load_entries(256, "t7_reload");
`endif

        rand_traffic(200, "final_rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
